mcp4922_rx: RTL
===============

Name: mcp4922_rx

Overview:
- Synthesizable receiver for the MCP4922 SPI frame format.
- It is the slave end of the serial link that the DAC driver transmits on. It deserializes 16-bit frames, holds per-channel input registers, and transfers them to the output registers under LDAC.
- Used as an in-fabric loopback target for bench and board self-test. Its outputs mirror what the physical DAC would show on the X (A) and Y (B) axes.
- All SPI inputs are asynchronous to clk and are oversampled.

Parameters:
- SYNC_STAGES, 2: synchronizer flip-flop depth on sck, sdi, cs_n and ldac_n. Legal range is 2..4.

Ports:
- clk  input  1  system clock. Must be at least 4x the SCK frequency.
- reset  input  1  asynchronous, active-high reset.
- sck  input  1  SPI clock, idle low (mode 0,0).
- sdi  input  1  SPI data, MSB first.
- cs_n  input  1  frame select, active low.
- ldac_n  input  1  latch enable, active low, level-sensitive.
- dac_a  output  12  channel A (X) output register.
- dac_b  output  12  channel B (Y) output register.
- cfg_a  output  3  channel A config from the last accepted frame: {BUF, GA_n, SHDN_n}.
- cfg_b  output  3  channel B config from the last accepted frame: {BUF, GA_n, SHDN_n}.
- frame_valid  output  1  one-cycle pulse when a frame is accepted.
- frame_error  output  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset (async assert, sync-released internally):
  - dac_a, dac_b, both input registers, shift register and bit counter = 0.
  - cfg_a = cfg_b = 3'b000.
  - frame_valid = frame_error = 0.
  - Synchronizers are preset: cs_n and ldac_n to 1, sck to 0.
- Synchronization and edge detection:
  - Each input passes through SYNC_STAGES flip-flops.
  - Edges are detected by comparing the last sync stage against one extra register.
  - Input-to-edge-event latency is SYNC_STAGES+1 clk cycles.
- States: IDLE, SHIFT.
  - IDLE -> SHIFT on synced cs_n falling edge. Clears the shift register and the bit counter.
  - In SHIFT, each synced sck rising edge shifts sdi into the LSB and increments the counter. The counter saturates at 17; 17 means overflow.
  - sck edges in IDLE are ignored.
  - SHIFT -> IDLE on synced cs_n rising edge.
- Frame decode, 16 bits:
  - bit15 selects the channel: 0 = A, 1 = B.
  - bit14 = BUF, bit13 = GA_n, bit12 = SHDN_n.
  - bits 11:0 = data.
- Commit, on the cycle after the cs_n rising edge is detected:
  - count == 16: write data to the selected input register, write {BUF, GA_n, SHDN_n} to the selected cfg output, pulse frame_valid.
  - Any other count: leave all registers unchanged, pulse frame_error.
  - A cs_n rise with zero clocks is also an error.
- LDAC:
  - While synced ldac_n = 0, dac_a and dac_b load from the input registers every clk. Outputs lag the input registers by one cycle.
  - While ldac_n = 1, outputs hold.
- Simultaneous events:
  - Commit and ldac_n low in the same cycle: the new input value appears on the output one cycle after the commit.
  - A cs_n fall in the same cycle as a commit: the commit completes first, then the next frame starts clean.
- Reset mid-frame: the partial frame is lost, no pulse is produced, the state returns to IDLE.
- Glitches: a cs_n pulse shorter than 1 clk after sync may be missed. That is acceptable because the clk >= 4x SCK rule covers it.

Optional Feature:
- Macro: MCP4922_RX_SHDN_EN.
- Defined: a channel whose cfg SHDN_n = 0 drives its dac_* output as 12'h000 regardless of LDAC. The held register value is kept, and it reappears on the next LDAC transfer after a frame with SHDN_n = 1.
- Undefined: SHDN_n is only reported on cfg_*, and outputs follow LDAC unconditionally.

Test Plan:
- Frame 0x3ABC (ch A, BUF=0, GA_n=1, SHDN_n=1, data 0xABC), then ldac_n low -> frame_valid pulses once, then dac_a = 0xABC, cfg_a = 3'b011, dac_b = 0.
- Frame 0xB123 with ldac_n held high, then 5 idle cycles, then an ldac_n low pulse -> dac_b stays 0 until the pulse, then becomes 0x123; cfg_b = 3'b011.
- 15-bit frame, then 17-bit frame -> frame_error pulses twice, no frame_valid, dac_a, dac_b and cfg_* unchanged.
- sck toggled 8 times with cs_n high, then a valid frame 0x3555 -> the stray clocks are ignored, and dac_a = 0x555 after LDAC.
- reset asserted after 9 bits of frame 0x3FFF, then released, then frame 0x3001 with LDAC -> no pulse for the aborted frame, and dac_a = 0x001.
- With MCP4922_RX_SHDN_EN: frame 0x2777 (SHDN_n=0) plus LDAC -> dac_a = 0x000. Then frame 0x3777 plus LDAC -> dac_a = 0x777.

Source files
------------

// File: rtl/mcp4922_rx.sv
// Slave-side receiver for MCP4922 16-bit SPI frames (mode 0,0), oversampled on clk.
// Optional macro MCP4922_RX_SHDN_EN: a channel with SHDN_n = 0 shows 12'h000 on its dac output.
module mcp4922_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        sdi,
  input  logic        cs_n,
  input  logic        ldac_n,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [2:0]  cfg_a,
  output logic [2:0]  cfg_b,
  output logic        frame_valid,
  output logic        frame_error
);

  // Synchronizer lanes are packed as {ldac_n, cs_n, sdi, sck}.
  localparam logic [3:0] SYNC_INIT = 4'b1100;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic                        rst_meta, rst_int;
  logic [SYNC_STAGES-1:0][3:0] sync_reg;
  logic [3:0]                  synced;
  logic [1:0]                  last_reg;     // {cs_n, sck} one stage behind synced
  logic                        sck_rise, cs_fall, cs_rise, sdi_s, ldac_active;

  state_t                      state_reg;
  logic [15:0]                 shift_reg;
  logic [4:0]                  count_reg;
  logic                        commit_reg;
  logic [11:0]                 input_a_reg, input_b_reg;
  logic [11:0]                 dac_a_reg, dac_b_reg;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_meta <= 1'b1;
      rst_int  <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_int  <= rst_meta;
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      sync_reg <= {SYNC_STAGES{SYNC_INIT}};
      last_reg <= SYNC_INIT[2:1] & 2'b10;
    end else begin
      sync_reg[0] <= {ldac_n, cs_n, sdi, sck};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_reg[i] <= sync_reg[i-1];
      last_reg <= {sync_reg[SYNC_STAGES-1][2], sync_reg[SYNC_STAGES-1][0]};
    end
  end

  assign synced      = sync_reg[SYNC_STAGES-1];
  assign sck_rise    = synced[0] & ~last_reg[0];
  assign cs_fall     = ~synced[2] & last_reg[1];
  assign cs_rise     = synced[2] & ~last_reg[1];
  assign sdi_s       = synced[1];
  assign ldac_active = ~synced[3];

  // Frame FSM; a commit is evaluated one cycle after the cs_n rise, before any new frame clears state.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      count_reg   <= '0;
      commit_reg  <= 1'b0;
      input_a_reg <= '0;
      input_b_reg <= '0;
      cfg_a       <= 3'b000;
      cfg_b       <= 3'b000;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      commit_reg  <= 1'b0;

      if (commit_reg) begin
        if (count_reg == 5'd16) begin
          if (shift_reg[15]) begin
            input_b_reg <= shift_reg[11:0];
            cfg_b       <= shift_reg[14:12];
          end else begin
            input_a_reg <= shift_reg[11:0];
            cfg_a       <= shift_reg[14:12];
          end
          frame_valid <= 1'b1;
        end else begin
          frame_error <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_reg <= SHIFT;
            shift_reg <= '0;
            count_reg <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_reg  <= IDLE;
            commit_reg <= 1'b1;
          end else if (sck_rise) begin
            shift_reg <= {shift_reg[14:0], sdi_s};
            if (count_reg != 5'd17)
              count_reg <= count_reg + 5'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      dac_a_reg <= '0;
      dac_b_reg <= '0;
    end else if (ldac_active) begin
      dac_a_reg <= input_a_reg;
      dac_b_reg <= input_b_reg;
    end
  end

`ifdef MCP4922_RX_SHDN_EN
  // A shutdown stays visible until an LDAC transfer happens with SHDN_n = 1.
  logic shdn_a_reg, shdn_b_reg;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      shdn_a_reg <= 1'b0;
      shdn_b_reg <= 1'b0;
    end else if (ldac_active) begin
      shdn_a_reg <= ~cfg_a[0];
      shdn_b_reg <= ~cfg_b[0];
    end else begin
      shdn_a_reg <= shdn_a_reg | ~cfg_a[0];
      shdn_b_reg <= shdn_b_reg | ~cfg_b[0];
    end
  end

  assign dac_a = (shdn_a_reg | ~cfg_a[0]) ? 12'h000 : dac_a_reg;
  assign dac_b = (shdn_b_reg | ~cfg_b[0]) ? 12'h000 : dac_b_reg;
`else
  assign dac_a = dac_a_reg;
  assign dac_b = dac_b_reg;
`endif

endmodule
